nand3_test_sequencer: RTL and testbench
=======================================

NAND3_TEST_SEQUENCER -- requirements
Module: nand3_test_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 2, idle cycles between driving a vector and sampling Y (legal range 0..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request an exhaustive test run.
REQ-005 SHALL have port: Y  input  1  output of the 3-input NAND under test.
REQ-006 SHALL have port: A, B, C  output  1 each  registered gate inputs.
REQ-007 SHALL have port: busy  output  1  run in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse at run end.
REQ-009 SHALL have port: pass  output  1  last run had zero mismatches.
REQ-010 SHALL have port: err_count  output  4  mismatches in last/current run.
REQ-011 SHALL have port: mismatch_map  output  8  bit i set when vector i mismatched.
REQ-012 SHALL have port: vec_idx  output  3  vector currently applied.

Function
REQ-013 SHALL use FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-014 SHALL leave IDLE for DRIVE on the edge where start=1; busy=1 in every state except IDLE.
REQ-015 SHALL on entering DRIVE from IDLE clear err_count, mismatch_map, pass and set vec_idx=0.
REQ-016 SHALL drive {A,B,C}=vec_idx (A = MSB) from DRIVE through SAMPLE of that vector.
REQ-017 SHALL spend 1 cycle in DRIVE, exactly SETTLE_CYCLES cycles in SETTLE (skipped when 0), and 1 cycle in SAMPLE; SETTLE_CYCLES+2 cycles per vector.
REQ-018 SHALL in SAMPLE compare Y against expected ~(A&B&C); Y of X/Z counts as mismatch.
REQ-019 SHALL on mismatch increment err_count (saturating at 15) and set mismatch_map[vec_idx].
REQ-020 SHALL after SAMPLE with vec_idx<7 increment vec_idx and go to DRIVE; with vec_idx=7 go to DONE (no wrap-around).
REQ-021 SHALL in DONE assert done for exactly one cycle, set pass=(err_count==0 including the final sample), then return to IDLE.
REQ-022 SHALL ignore start while busy=1; start held high in IDLE/after DONE begins a new run on the next edge.
REQ-023 SHALL hold err_count, mismatch_map, pass, vec_idx stable in IDLE until the next run starts.
REQ-024 SHALL complete a run with done in cycle k+1+8*(SETTLE_CYCLES+2) when start is sampled at edge k.

Reset
REQ-025 SHALL on rst=1 (priority over start, any state, including mid-run) force state IDLE, A=B=C=0, busy=0, done=0, pass=0, err_count=0, mismatch_map=0, vec_idx=0.
REQ-026 SHALL not start a run in the cycle rst is asserted even if start=1.

Configuration
REQ-027 SHALL support macro NAND3_SEQ_STOP_ON_FAIL_EN.
REQ-028 SHALL with NAND3_SEQ_STOP_ON_FAIL_EN defined go from SAMPLE directly to DONE on the first mismatch, leaving vec_idx at the failing vector.
REQ-029 SHALL without the macro always run all 8 vectors regardless of mismatches.

Structure
REQ-030 SHALL take state enum, VEC_COUNT=8, and err_count/vec_idx widths from shared package nand3_seq_pkg.
REQ-031 SHALL place the expected-value model in sub-module nand3_ref (inputs A,B,C, output Y_exp), purely combinational.
REQ-032 SHALL implement SETTLE timing with a 4-bit down-counter loaded on DRIVE.

Verification
REQ-033 SHALL cover: correct nand3 attached, SETTLE_CYCLES=2, one start pulse -> done 33 cycles later, pass=1, err_count=0, mismatch_map=8'h00.
REQ-034 SHALL cover: Y stuck at 1 -> err_count=1, mismatch_map=8'h80, pass=0.
REQ-035 SHALL cover: Y stuck at 0, macro undefined -> err_count=7, mismatch_map=8'h7F; macro defined -> done after vector 0, err_count=1, mismatch_map=8'h01, vec_idx=0.
REQ-036 SHALL cover: rst asserted at vector 3 SETTLE -> next cycle all outputs at reset values, state IDLE; subsequent start runs full 8 vectors.
REQ-037 SHALL cover: start pulsed at vector 5 -> ignored, single done pulse; SETTLE_CYCLES=0 -> done 17 cycles after start.

Source files
------------

// File: rtl/nand3_seq_pkg.sv
// rtl/nand3_seq_pkg.sv - shared FSM states, vector count and field widths for the nand3 test sequencer
package nand3_seq_pkg;

  localparam int VEC_COUNT = 8;
  localparam int VEC_W     = 3;
  localparam int ERR_W     = 4;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/nand3_ref.sv
// rtl/nand3_ref.sv - combinational golden model of a 3-input NAND
module nand3_ref (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Y_exp
);

  assign Y_exp = ~(A & B & C);

endmodule

// File: rtl/nand3_test_sequencer.sv
// rtl/nand3_test_sequencer.sv - exhaustive 8-vector tester for an external 3-input NAND
// Optional NAND3_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module nand3_test_sequencer
  import nand3_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 Y,
  output logic                 A,
  output logic                 B,
  output logic                 C,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [VEC_COUNT-1:0] mismatch_map,
  output logic [VEC_W-1:0]     vec_idx
);

`ifdef NAND3_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(VEC_COUNT - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic             y_exp;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  nand3_ref u_ref (
    .A     (A),
    .B     (B),
    .C     (C),
    .Y_exp (y_exp)
  );

  // Written as "match else mismatch" so an unknown Y lands on the mismatch side.
  always_comb begin
    mismatch = 1'b1;
    if (Y == y_exp) mismatch = 1'b0;
  end

  assign err_next = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      {A, B, C}    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      mismatch_map <= '0;
      vec_idx      <= '0;
      settle_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= DRIVE;
            busy         <= 1'b1;
            err_count    <= '0;
            mismatch_map <= '0;
            pass         <= 1'b0;
            vec_idx      <= '0;
            {A, B, C}    <= '0;
          end
        end
        DRIVE: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count             <= err_next;
            mismatch_map[vec_idx] <= 1'b1;
          end
          // pass folds in this final sample since err_count has not updated yet
          if (vec_idx == LAST_VEC || (mismatch && STOP_ON_FAIL)) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == '0);
          end else begin
            state     <= DRIVE;
            vec_idx   <= vec_idx + 1'b1;
            {A, B, C} <= vec_idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand3_test_sequencer.sv
// tb/tb_nand3_test_sequencer.sv - scoreboard bench for nand3_test_sequencer (SETTLE_CYCLES 2 and 0)
module tb_nand3_test_sequencer;

`ifdef NAND3_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  localparam int SETTLE = 2;

  typedef struct {
    logic [3:0] err;
    logic [7:0] map;
    logic       pass;
    logic [2:0] vec;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, y;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] mismatch_map;
  logic [2:0] vec_idx;
  int         mode;

  logic       start0, y0;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [7:0] map0;
  logic [2:0] vec0;

  // mode 0: healthy gate, 1: Y stuck at 1, 2: Y stuck at 0
  assign y  = (mode == 0) ? ~(a & b & c) : (mode == 1);
  assign y0 = ~(a0 & b0 & c0);

  nand3_test_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .Y(y),
    .A(a), .B(b), .C(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .mismatch_map(mismatch_map), .vec_idx(vec_idx)
  );

  nand3_test_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .Y(y0),
    .A(a0), .B(b0), .C(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .mismatch_map(map0), .vec_idx(vec0)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int m, input int s);
    exp_t e;
    int   nvec;
    logic good, got;
    e.err = '0; e.map = '0; e.vec = '0; nvec = 8;
    for (int i = 0; i < 8; i++) begin
      good  = ~(i[2] & i[1] & i[0]);
      got   = (m == 0) ? good : (m == 1);
      e.vec = i[2:0];
      if (got != good) begin
        e.err = e.err + 4'd1;
        e.map[i] = 1'b1;
        if (STOP_EN) begin
          nvec = i + 1;
          break;
        end
      end
    end
    e.pass = (e.err == 4'd0);
    e.lat  = 1 + nvec * (s + 2);
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_err"}, err_count, 4'd0);
    check({tag, "_map"}, mismatch_map, 8'h00);
    check({tag, "_vec"}, vec_idx, 3'd0);
    check({tag, "_abc"}, {a, b, c}, 3'b000);
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic run(input int m, input bit mid_start);
    exp_t e;
    int   n, bad_vec, extra_done;
    bit   seen;
    logic [3:0] err_hold;
    mode  = m;
    start = 1'b1;
    sb.push_back(model(m, SETTLE));
    @(negedge clk);
    start = 1'b0;
    check("run_busy_rise", busy, 1'b1);
    n = 0; seen = 0; bad_vec = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      start = (mid_start && n == 21);
      if (busy && {a, b, c} !== vec_idx) bad_vec++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("run_done_seen", seen, 1'b1);
    e = sb.pop_front();
    check("run_latency", n + 1, e.lat);
    check("run_err", err_count, e.err);
    check("run_map", mismatch_map, e.map);
    check("run_pass", pass, e.pass);
    check("run_vec", vec_idx, e.vec);
    check("run_abc_tracks_vec", bad_vec, 0);
    err_hold = err_count;
    @(negedge clk);
    check("run_done_pulse", done, 1'b0);
    check("run_busy_fall", busy, 1'b0);
    if (mid_start) begin
      extra_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) extra_done++;
      end
      check("midstart_no_rerun", extra_done, 0);
      check("idle_err_hold", err_count, err_hold);
      check("idle_pass_hold", pass, e.pass);
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; start = 1'b1; start0 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    run(0, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);

    // Reset in the middle of vector 3's settle window, with start also high.
    mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    check("mid_vec", vec_idx, 3'd3);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrst_no_start", busy, 1'b0);
    run(0, 1'b0);

    run(0, 1'b1);

    // SETTLE_CYCLES=0 instance: two cycles per vector.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done0) seen = 1;
    end
    check("s0_done_seen", seen, 1'b1);
    check("s0_latency", n + 1, 17);
    check("s0_pass", pass0, 1'b1);
    check("s0_err", err0, 4'd0);
    check("s0_map", map0, 8'h00);
    check("s0_vec", vec0, 3'd7);
    check("s0_abc", {a0, b0, c0}, 3'b111);
    @(negedge clk);
    check("s0_busy_fall", busy0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
